// File: rtl/forward_control.sv
// Hazard/forwarding controller: tracks EX/MEM/WB destinations, registers forward selects, raises load-use stall.
// Latency: selects valid 1 cycle after issue (consumer in EX); stall is combinational (0 cycles).
// Backpressure: stall holds PC and IF/ID and forces a bubble into EX; flush overrides stall.
// Optional WB-distance forwarding is enabled by defining FWD_WB_EN.
module forward_control #(
  parameter int REGADDR     = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REGADDR-1:0]     id_rs,
  input  logic [REGADDR-1:0]     id_rt,
  input  logic                   id_use_rs,
  input  logic                   id_use_rt,
  input  logic [REGADDR-1:0]     id_rd,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   flush,
  output logic                   forward1,
  output logic                   forward2,
  output logic                   memForward1,
  output logic                   memForward2,
  output logic                   wbForward1,
  output logic                   wbForward2,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic               valid;
    logic [REGADDR-1:0] rd;
    logic               reg_write;
    logic               mem_read;
  } hist_t;

  // Past EX only the load flag no longer matters, so older entries drop it.
  typedef struct packed {
    logic               valid;
    logic [REGADDR-1:0] rd;
    logic               reg_write;
  } fwd_hist_t;

  hist_t     h0;
  hist_t     h0_nxt;
  fwd_hist_t h1;
`ifdef FWD_WB_EN
  fwd_hist_t h2;
`endif

  logic issue;
  logic rs_h0, rt_h0, rs_h1, rt_h1;

  function automatic logic src_hit(
    input logic               valid,
    input logic               reg_write,
    input logic [REGADDR-1:0] rd,
    input logic [REGADDR-1:0] src,
    input logic               use_src
  );
    return valid & reg_write & (rd != '0) & (src == rd) & use_src;
  endfunction

  assign rs_h0 = src_hit(h0.valid, h0.reg_write, h0.rd, id_rs, id_use_rs);
  assign rt_h0 = src_hit(h0.valid, h0.reg_write, h0.rd, id_rt, id_use_rt);
  assign rs_h1 = src_hit(h1.valid, h1.reg_write, h1.rd, id_rs, id_use_rs);
  assign rt_h1 = src_hit(h1.valid, h1.reg_write, h1.rd, id_rt, id_use_rt);

  // A load in EX cannot feed its data to the very next instruction; flush wins.
  assign stall = id_valid & ~flush & h0.mem_read & (rs_h0 | rt_h0);
  assign issue = id_valid & ~flush & ~stall;

  always_comb begin
    h0_nxt = '0;
    if (issue) begin
      h0_nxt.valid     = 1'b1;
      h0_nxt.rd        = id_rd;
      h0_nxt.reg_write = id_reg_write;
      h0_nxt.mem_read  = id_mem_read;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0 <= '0;
      h1 <= '0;
    end else begin
      h0 <= h0_nxt;
      h1 <= '{valid: h0.valid, rd: h0.rd, reg_write: h0.reg_write};
    end
  end

  // Nearest producer wins per operand; each operand resolves independently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      forward1    <= 1'b0;
      forward2    <= 1'b0;
      memForward1 <= 1'b0;
      memForward2 <= 1'b0;
    end else begin
      forward1    <= issue & rs_h0;
      forward2    <= issue & rt_h0;
      memForward1 <= issue & ~rs_h0 & rs_h1;
      memForward2 <= issue & ~rt_h0 & rt_h1;
    end
  end

`ifdef FWD_WB_EN
  logic rs_h2, rt_h2;

  assign rs_h2 = src_hit(h2.valid, h2.reg_write, h2.rd, id_rs, id_use_rs);
  assign rt_h2 = src_hit(h2.valid, h2.reg_write, h2.rd, id_rt, id_use_rt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h2         <= '0;
      wbForward1 <= 1'b0;
      wbForward2 <= 1'b0;
    end else begin
      h2         <= h1;
      wbForward1 <= issue & ~rs_h0 & ~rs_h1 & rs_h2;
      wbForward2 <= issue & ~rt_h0 & ~rt_h1 & rt_h2;
    end
  end
`else
  // Register file write-before-read covers distance-3 producers.
  assign wbForward1 = 1'b0;
  assign wbForward2 = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_forward_control.sv
// Directed bench for forward_control: stimulus pushes expected observations, a negedge monitor pops and compares.
module tb_forward_control;

  localparam int CW = 3;
`ifdef FWD_WB_EN
  localparam logic WB = 1'b1;
`else
  localparam logic WB = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          id_use_rs, id_use_rt, id_reg_write, id_mem_read, flush;
  logic          forward1, forward2, memForward1, memForward2, wbForward1, wbForward2;
  logic          stall;
  logic [CW-1:0] stall_count;

  forward_control #(.REGADDR(5), .STALL_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush),
    .forward1(forward1), .forward2(forward2),
    .memForward1(memForward1), .memForward2(memForward2),
    .wbForward1(wbForward1), .wbForward2(wbForward2),
    .stall(stall), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sel order: {forward1, forward2, memForward1, memForward2, wbForward1, wbForward2}
  typedef struct {
    string         name;
    logic          st;
    logic [5:0]    sel;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  wire [5:0] sel_obs = {forward1, forward2, memForward1, memForward2, wbForward1, wbForward2};

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (stall !== e.st) begin
        errors++;
        $display("FAIL %s stall: got %0b want %0b", e.name, stall, e.st);
      end
      checks++;
      if (sel_obs !== e.sel) begin
        errors++;
        $display("FAIL %s selects: got %06b want %06b", e.name, sel_obs, e.sel);
      end
      checks++;
      if (stall_count !== e.cnt) begin
        errors++;
        $display("FAIL %s stall_count: got %0d want %0d", e.name, stall_count, e.cnt);
      end
    end
  end

  task automatic ins(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                     input int rd, input logic rw, input logic mr, input logic fl);
    id_valid     = v;
    id_rs        = rs[4:0];
    id_rt        = rt[4:0];
    id_use_rs    = urs;
    id_use_rt    = urt;
    id_rd        = rd[4:0];
    id_reg_write = rw;
    id_mem_read  = mr;
    flush        = fl;
  endtask

  task automatic expect_obs(input string nm, input logic st, input logic [5:0] sel, input int cnt);
    exp_t x;
    x.name = nm;
    x.st   = st;
    x.sel  = sel;
    x.cnt  = (cnt > 7) ? 3'd7 : cnt[CW-1:0];
    q.push_back(x);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    expect_obs("reset", 0, 6'b000000, 0);
    tick;
    rst_n = 1'b1;

    ins(1, 1, 2, 1, 1, 3, 1, 0, 0);            // add $3,$1,$2
    expect_obs("add3", 0, 6'b000000, 0);
    tick;
    ins(1, 3, 5, 1, 1, 4, 1, 0, 0);            // sub $4,$3,$5
    expect_obs("sub4", 0, 6'b000000, 0);
    tick;
    ins(1, 1, 0, 1, 0, 5, 1, 1, 0);            // lw $5,0($1)
    expect_obs("dist1_fwd", 0, 6'b100000, 0);
    tick;
    ins(1, 2, 5, 1, 1, 6, 1, 0, 0);            // add $6,$2,$5 : load-use
    expect_obs("loaduse_stall", 1, 6'b000000, 0);
    tick;
    expect_obs("loaduse_replay", 0, 6'b000000, 1);
    tick;
    ins(1, 1, 1, 1, 1, 7, 1, 0, 0);            // add $7,$1,$1
    expect_obs("loaduse_memfwd", 0, 6'b000100, 1);
    tick;
    ins(1, 2, 2, 1, 1, 7, 1, 0, 0);            // or $7,$2,$2
    expect_obs("or7", 0, 6'b000000, 1);
    tick;
    ins(1, 7, 7, 1, 1, 8, 1, 0, 0);            // and $8,$7,$7
    expect_obs("and8", 0, 6'b000000, 1);
    tick;
    ins(1, 1, 0, 1, 0, 0, 1, 0, 0);            // addi $0,$1,4
    expect_obs("nearest_wins", 0, 6'b110000, 1);
    tick;
    ins(1, 0, 0, 1, 1, 2, 1, 0, 0);            // add $2,$0,$0
    expect_obs("addi0", 0, 6'b000000, 1);
    tick;
    ins(1, 1, 1, 1, 1, 9, 1, 0, 0);            // add $9,$1,$1
    expect_obs("reg0_nomatch", 0, 6'b000000, 1);
    tick;
    ins(1, 10, 11, 1, 1, 0, 0, 0, 0);          // non-writing
    expect_obs("nw1", 0, 6'b000000, 1);
    tick;
    ins(1, 12, 13, 1, 1, 0, 0, 0, 0);          // non-writing
    expect_obs("nw2", 0, 6'b000000, 1);
    tick;
    ins(1, 9, 3, 1, 1, 10, 1, 0, 0);           // sub $10,$9,$3
    expect_obs("sub10", 0, 6'b000000, 1);
    tick;
    ins(1, 10, 0, 1, 0, 11, 1, 1, 0);          // lw $11,0($10)
    expect_obs("dist3", 0, {4'b0000, WB, 1'b0}, 1);
    tick;
    ins(1, 10, 11, 1, 1, 12, 1, 0, 1);         // load-use but flushed
    expect_obs("flush_nostall", 0, 6'b100000, 1);
    tick;
    ins(1, 10, 11, 1, 1, 13, 1, 0, 0);         // and $13,$10,$11
    expect_obs("flush_bubble", 0, 6'b000000, 1);
    tick;
    ins(1, 13, 11, 1, 1, 14, 1, 0, 0);         // or $14,$13,$11
    expect_obs("mixed_mem_wb", 0, {3'b000, 1'b1, WB, 1'b0}, 1);
    tick;
    ins(1, 1, 0, 1, 0, 15, 1, 1, 0);           // lw $15,0($1)
    expect_obs("mixed_ex_wb", 0, {1'b1, 4'b0000, WB}, 1);
    tick;
    ins(1, 15, 15, 1, 1, 16, 1, 0, 0);         // add $16,$15,$15
    expect_obs("stall2", 1, 6'b000000, 1);
    tick;
    expect_obs("stall2_replay", 0, 6'b000000, 2);
    tick;
    ins(1, 1, 0, 1, 0, 17, 1, 1, 0);           // lw $17,0($1)
    expect_obs("both_memfwd", 0, 6'b001100, 2);
    tick;
    ins(1, 17, 2, 1, 1, 18, 1, 0, 0);          // add $18,$17,$2
    expect_obs("stall3", 1, 6'b000000, 2);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    expect_obs("reset_midstall", 0, 6'b000000, 0);
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_obs("post_reset", 0, 6'b000000, 0);
    tick;

    for (int i = 0; i < 8; i++) begin
      ins(1, 1, 0, 1, 0, 20, 1, 1, 0);         // lw $20,0($1)
      expect_obs("sat_lw", 0, (i == 0) ? 6'b000000 : 6'b001000, i);
      tick;
      ins(1, 20, 0, 1, 0, 21, 1, 0, 0);        // add $21,$20,$0
      expect_obs("sat_stall", 1, 6'b000000, i);
      tick;
      expect_obs("sat_replay", 0, 6'b000000, i + 1);
      tick;
    end
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_obs("sat_final", 0, 6'b001000, 7);
    tick;

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
